// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns one core load/store into a single valid/ack bus
// transaction with byte enables, and returns extended load data or an error strobe.
package dmem_bridge_pkg;
  typedef enum logic [3:0] {
    LOAD_STORE_NONE    = 4'd0,
    LOAD_BYTE          = 4'd1,
    LOAD_BYTE_UNSIGNED = 4'd2,
    LOAD_HALF          = 4'd3,
    LOAD_HALF_UNSIGNED = 4'd4,
    LOAD_WORD          = 4'd5,
    STORE_BYTE         = 4'd6,
    STORE_HALF         = 4'd7,
    STORE_WORD         = 4'd8
  } mem_op_t;
endpackage

module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  mem_op_t     dmem_op,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_busy,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        in_byte, in_half, in_store, in_valid, misaligned;
  logic        op_load;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  always_comb begin
    in_valid   = (dmem_op != LOAD_STORE_NONE);
    in_byte    = dmem_op inside {LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE};
    in_half    = dmem_op inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF};
    in_store   = dmem_op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
    misaligned = in_half ? dmem_addr[0] : (!in_byte && (dmem_addr[1:0] != 2'b00));
  end

  // Lane extraction uses the latched low address bits and op, not the live inputs.
  always_comb begin
    op_load = op_q inside {LOAD_BYTE, LOAD_BYTE_UNSIGNED, LOAD_HALF,
                           LOAD_HALF_UNSIGNED, LOAD_WORD};
    lane_b  = 8'(bus_rdata >> {addr_q, 3'b000});
    lane_h  = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      LOAD_BYTE:          load_val = {{24{lane_b[7]}}, lane_b};
      LOAD_BYTE_UNSIGNED: load_val = {24'b0, lane_b};
      LOAD_HALF:          load_val = {{16{lane_h[15]}}, lane_h};
      LOAD_HALF_UNSIGNED: load_val = {16'b0, lane_h};
      default:            load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = misaligned ? DONE : BUS;
      BUS:  if (bus_ack || (cnt_q == CNT_LAST)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_busy   = resetn && (((state_q == IDLE) && in_valid) || (state_q == BUS));
    op_d        = op_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    error_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = dmem_op;
          addr_d = dmem_addr[1:0];
          cnt_d  = '0;
          if (misaligned) begin
            error_d = 1'b1;
            if (!in_store) rdata_d = '0;
          end else begin
            bus_req_d  = 1'b1;
            bus_we_d   = in_store;
            bus_addr_d = {dmem_addr[31:2], 2'b00};
            if (in_byte) begin
              bus_be_d    = 4'b0001 << dmem_addr[1:0];
              bus_wdata_d = {4{dmem_wdata[7:0]}};
            end else if (in_half) begin
              bus_be_d    = dmem_addr[1] ? 4'b1100 : 4'b0011;
              bus_wdata_d = {2{dmem_wdata[15:0]}};
            end else begin
              bus_be_d    = 4'b1111;
              bus_wdata_d = dmem_wdata;
            end
          end
        end
      end
      BUS: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          error_d   = bus_err;
          if (op_load) rdata_d = bus_err ? '0 : load_val;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          error_d   = 1'b1;
          if (op_load) rdata_d = '0;
        end
      end
      DONE: cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= LOAD_STORE_NONE;
      addr_q      <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign dmem_rdata = rdata_q;
  assign dmem_error = error_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed and random accesses checked against an
// arithmetic model of addressing, lane selection and extension.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  mem_op_t     dmem_op;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_busy, dmem_error;
  logic [31:0] dmem_rdata;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .dmem_op(dmem_op), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_busy(dmem_busy), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned op_size(input mem_op_t op);
    case (op)
      LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE: return 1;
      LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == STORE_BYTE) || (op == STORE_HALF) || (op == STORE_WORD);
  endfunction

  function automatic logic is_signed(input mem_op_t op);
    return (op == LOAD_BYTE) || (op == LOAD_HALF);
  endfunction

  // ack_at: BUS cycle (1-based) carrying bus_ack; 0 means never acknowledge.
  task automatic access(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned ack_at, input logic [31:0] rword, input logic err);
    int unsigned sz, off;
    logic [31:0] ea, ebe, ewd, mask, v;
    logic mis, eerr, acked;
    sz   = op_size(op);
    off  = addr % 4;
    mis  = (addr % sz) != 0;
    ea   = addr - off;
    ebe  = 32'((1 << sz) - 1) << off;
    ewd  = (sz == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
           (sz == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
    dmem_op = op; dmem_addr = addr; dmem_wdata = wdata;
    #1;
    chk("busy_on_request", dmem_busy, 1);
    @(posedge clk); #1;
    acked = 1'b0;
    if (mis) begin
      eerr = 1'b1;
    end else begin
      for (int n = 1; n <= TO && !acked; n++) begin
        chk("bus_req_held", bus_req, 1);
        chk("busy_in_bus", dmem_busy, 1);
        chk("bus_addr", bus_addr, ea);
        chk("bus_be", bus_be, ebe);
        chk("bus_we", bus_we, is_store(op));
        chk("bus_wdata", bus_wdata, ewd);
        if (n == ack_at) begin
          bus_ack = 1'b1; bus_rdata = rword; bus_err = err; acked = 1'b1;
        end else begin
          bus_rdata = $urandom;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_err = 1'b0;
      end
      eerr = acked ? err : 1'b1;
    end
    if (!is_store(op)) begin
      if (eerr) exp_rdata = '0;
      else begin
        v    = rword >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
        v    = v & mask;
        if (is_signed(op) && v[8*sz-1]) v = v | ~mask;
        exp_rdata = v;
      end
    end
    chk("done_busy", dmem_busy, 0);
    chk("done_bus_req", bus_req, 0);
    chk("done_error", dmem_error, eerr);
    chk("done_rdata", dmem_rdata, exp_rdata);
    dmem_op = LOAD_STORE_NONE;
    @(posedge clk); #1;
    chk("idle_error_clear", dmem_error, 0);
    chk("idle_busy", dmem_busy, 0);
  endtask

  mem_op_t ops [8] = '{LOAD_BYTE, LOAD_BYTE_UNSIGNED, LOAD_HALF, LOAD_HALF_UNSIGNED,
                       LOAD_WORD, STORE_BYTE, STORE_HALF, STORE_WORD};

  initial begin
    resetn = 1'b0; dmem_op = LOAD_STORE_NONE; dmem_addr = '0; dmem_wdata = '0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0; exp_rdata = '0;
    #12;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_rdata", dmem_rdata, 0);
    dmem_op = LOAD_WORD; #1;
    chk("rst_busy_low", dmem_busy, 0);
    dmem_op = LOAD_STORE_NONE;
    #4 resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_none_busy", dmem_busy, 0);

    access(LOAD_WORD,          32'h100, 32'h0,        1, 32'hDEADBEEF, 1'b0);
    access(LOAD_BYTE,          32'h103, 32'h0,        1, 32'h80FF1234, 1'b0);
    access(LOAD_BYTE_UNSIGNED, 32'h103, 32'h0,        1, 32'h80FF1234, 1'b0);
    access(LOAD_HALF,          32'h102, 32'h0,        1, 32'h80FF1234, 1'b0);
    access(STORE_HALF,         32'h206, 32'h1234ABCD, 3, 32'h0,        1'b0);
    access(LOAD_WORD,          32'h101, 32'h0,        1, 32'h11111111, 1'b0);
    access(LOAD_HALF_UNSIGNED, 32'h002, 32'h0,        2, 32'h9876F00D, 1'b0);
    access(STORE_WORD,         32'h300, 32'h55AA55AA, 0, 32'h0,        1'b0);
    access(STORE_HALF,         32'h301, 32'h0BAD0BAD, 1, 32'h0,        1'b0);
    access(STORE_BYTE,         32'h305, 32'h000000C3, 1, 32'h0,        1'b1);
    access(LOAD_WORD,          32'h400, 32'h0,        0, 32'h0,        1'b0);
    access(LOAD_HALF,          32'h402, 32'h0,        1, 32'h7FFF8000, 1'b0);
    access(LOAD_WORD,          32'h404, 32'h0,        2, 32'hCAFEF00D, 1'b1);

    for (int i = 0; i < 40; i++) begin
      access(ops[$urandom_range(0, 7)], $urandom, $urandom,
             $urandom_range(0, TO), $urandom, ($urandom_range(0, 5) == 0));
    end

    dmem_op = LOAD_WORD; dmem_addr = 32'h500; #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bus2_req", bus_req, 1);
    resetn = 1'b0; #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_busy", dmem_busy, 0);
    chk("arst_bus_addr", bus_addr, 0);
    chk("arst_bus_be", bus_be, 0);
    chk("arst_bus_wdata", bus_wdata, 0);
    chk("arst_bus_we", bus_we, 0);
    chk("arst_rdata", dmem_rdata, 0);
    chk("arst_error", dmem_error, 0);
    dmem_op = LOAD_STORE_NONE;
    #3 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_busy", dmem_busy, 0);
      chk("post_rst_req", bus_req, 0);
      chk("post_rst_error", dmem_error, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
